uart_tx_frame: RTL and testbench
================================

# uart_tx_frame

Serial framing engine of the UART transmit path. It sits directly downstream of the baud clock divider, `c_div`, and runs entirely in the `clk_cpu` domain. It uses each rising edge of `baud_clock` as a one-bit-time enable. It holds one byte in a transmit holding register (THR) and shifts it out through a transmit shift register (TSR) as start, data, optional parity and stop bits, under control of the LCR fields.

## Interface
- No parameters; the frame format is fully run-time programmable through LCR.
- `clk_cpu` in 1 — system clock; the only clock.
- `rst` in 1 — reset, asynchronous, active-high.
- `baud_clock` in 1 — from `c_div`; idles high; one rising edge per bit time.
- `thr_data` in 8 — byte to transmit.
- `thr_valid` in 1 — write strobe for `thr_data`.
- `thr_ready` out 1 — THR empty; a write is accepted when `thr_valid & thr_ready`.
- `lcr_wls` in 2 — word length: 00=5, 01=6, 10=7, 11=8 bits.
- `lcr_stb` in 1 — 0 selects one stop bit, 1 selects two stop bits (all word lengths).
- `lcr_pen` in 1 — parity enable.
- `lcr_eps` in 1 — 1 selects even parity, 0 selects odd.
- `lcr_sp` in 1 — stick parity; the parity bit is forced to `~lcr_eps`.
- `lcr_bc` in 1 — break control; forces the line low.
- `tx_out` out 1 — serial line; registered; idles high.
- `tx_busy` out 1 — a frame is in progress (FSM not in IDLE).
- `temt` out 1 — transmitter empty: THR empty and FSM in IDLE.

## Operation
- **Tick.** `baud_d` registers `baud_clock` and resets to 1. `tick = baud_clock & ~baud_d`, a pulse one `clk_cpu` cycle wide. If the divider is disabled, `baud_clock` stays high, no ticks occur, and the FSM freezes with `tx_out` held.
- **THR.** A write is accepted when `thr_valid & thr_ready`; the write captures `thr_data` and clears `thr_ready`. When the THR is full, further writes are ignored and no data is lost.
- **FSM states.** IDLE, START, DATA, PARITY, STOP. Transitions happen only on `tick`.
  - IDLE with THR full on `tick` → START. In that cycle: THR is moved to TSR, `thr_ready` is set, `tx_out` goes to 0, and the bit counter is cleared.
  - START on `tick` → DATA. `tx_out` = TSR[0], then TSR shifts right.
  - DATA on `tick`: the counter increments and the next bit is driven. After `wls+5` data bits: go to PARITY if `lcr_pen`, otherwise to STOP with `tx_out` = 1.
  - PARITY on `tick` → STOP with `tx_out` = 1.
  - STOP on `tick`: after 1 (or 2 if `lcr_stb`) stop bits, go to START if THR is full (back-to-back transfer, no idle gap), otherwise go to IDLE.
- **Parity value.** Computed from the TSR contents at load time, over the low `wls+5` bits only; bits above the word length are ignored.
  - `lcr_sp=1`: parity = `~lcr_eps`.
  - `lcr_sp=0`, even (`lcr_eps=1`): parity = XOR of the data bits.
  - `lcr_sp=0`, odd (`lcr_eps=0`): parity = XNOR of the data bits.
- **LCR sampling.** The word length, stop-bit count and parity fields are latched at the TSR load and stay stable for the whole frame. `lcr_bc` is not latched.
- **Break.** `tx_out` = `line_reg & ~lcr_bc`, computed in the output register. The frame keeps sequencing internally while the break is asserted. Clearing `lcr_bc` restores the current bit.
- **Reset values:**
  - `tx_out` = 1, `thr_ready` = 1, `tx_busy` = 0, `temt` = 1.
  - FSM = IDLE, TSR = 0, counter = 0.
- **Reset mid-frame.** Asserting `rst` aborts the frame immediately, discards the THR contents, and returns `tx_out` to 1 asynchronously.

## Timing
- Each line transition occurs on the `clk_cpu` edge after the tick cycle, i.e. 1 clock after the `baud_clock` rising edge is sampled.
- Write to start bit:
  - THR written in cycle N; the first tick in cycle T > N; `tx_out` = 0 from cycle T+1.
  - Worst case is one full bit period plus 1 clock after the write.
- Write coinciding with a tick (THR empty, FSM in IDLE): the byte is captured but not transferred; the frame starts on the following tick.
- `thr_ready` rises in the cycle after the TSR load, which is the same edge as the start bit. This allows a second write while the first frame is still shifting.
- Bit period = one full `baud_clock` period, i.e. the divisor value in `clk_cpu` cycles.
- Frame length in bit times = 1 + (`wls`+5) + `pen` + (1 + `stb`).
- `tx_busy` rises together with the start bit and falls on the last stop-bit tick when no byte is pending. `temt` = `thr_ready & ~tx_busy`.

## Test plan
- **8N1, single byte.**
  - Stimulus: bit period 16 clocks, `lcr_wls`=11, `pen`=0, `stb`=0; write 0x55.
  - Required: `tx_out` = 0,1,0,1,0,1,0,1,0,1 (start, 8 data, stop), each held 16 clocks; `temt` returns to 1 after 160 clocks of frame.
- **7E1 and stick parity.**
  - 7E1 (`wls`=10, `pen`=1, `eps`=1), write 0xC1: data bits 1,0,0,0,0,0,1, then parity 0; bit 7 ignored.
  - Same byte with `sp`=1, `eps`=0: parity bit = 1.
- **5O2.**
  - Stimulus: `wls`=00, `pen`=1, `eps`=0, `stb`=1; write 0x1F.
  - Required: data 1,1,1,1,1, parity 0, then two stop bits; frame is 9 bit times.
- **Back-to-back and overflow.**
  - Write 0xA5, then 0x3C after `thr_ready` rises: the second start bit immediately follows the first stop bit.
  - A third write while `thr_ready`=0 is ignored.
- **Break.**
  - Assert `lcr_bc` mid-data: `tx_out`=0 within 1 clock.
  - Deassert: `tx_out` shows the current bit; the frame ends at its normal time.
- **Reset and stall.**
  - Assert `rst` mid-frame: `tx_out`=1, `thr_ready`=1 and `temt`=1 immediately.
  - Hold `baud_clock`=1: a written byte stays pending, `tx_out` stays 1, and there is no spurious tick after reset.

Source files
------------

// File: rtl/uart_tx_frame.sv
// uart_tx_frame
// Transmit framing engine of the UART. It holds one byte in the transmit
// holding register (THR) and serialises it through the transmit shift
// register (TSR) as a start bit, 5..8 data bits, an optional parity bit and
// one or two stop bits. The frame advances once per rising edge of
// baud_clock, detected in the clk_cpu domain. The frame format is latched at
// TSR load, so LCR writes during a frame do not affect that frame. Break
// control is applied live at the output register.
module uart_tx_frame (
  input  logic       clk_cpu,
  input  logic       rst,
  input  logic       baud_clock,
  input  logic [7:0] thr_data,
  input  logic       thr_valid,
  output logic       thr_ready,
  input  logic [1:0] lcr_wls,
  input  logic       lcr_stb,
  input  logic       lcr_pen,
  input  logic       lcr_eps,
  input  logic       lcr_sp,
  input  logic       lcr_bc,
  output logic       tx_out,
  output logic       tx_busy,
  output logic       temt
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  // Registered state
  logic       baud_d_reg;
  logic [7:0] thr_reg, thr_next;
  logic       thr_full_reg, thr_full_next;
  state_t     state_reg, state_next;
  logic [7:0] tsr_reg, tsr_next;
  logic [2:0] cnt_reg, cnt_next;
  logic [1:0] wls_reg, wls_next;
  logic       stb_reg, stb_next;
  logic       pen_reg, pen_next;
  logic       par_reg, par_next;
  logic       line_reg, line_next;
  logic       tx_out_reg;

  // Combinational helpers
  logic       tick;
  logic       wr_accept;
  logic       load;
  logic [2:0] load_last_idx;
  logic [7:0] load_word;
  logic       load_xor;
  logic       load_parity;
  logic [2:0] last_data_idx;
  logic       last_data;
  logic       last_stop;

  // One-cycle pulse on each rising edge of the baud enable. baud_d resets
  // high so that a baud_clock that is already high does not fire a tick.
  assign tick      = baud_clock & ~baud_d_reg;
  assign wr_accept = thr_valid & ~thr_full_reg;

  // Index of the last data bit for the word length currently on LCR; used
  // when the THR is moved into the TSR.
  assign load_last_idx = {1'b0, lcr_wls} + 3'd4;

  // Mask off THR bits above the word length so they cannot influence parity.
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_word_mask
      assign load_word[gi] = thr_reg[gi] & (3'(gi) <= load_last_idx);
    end
  endgenerate

  // Parity bit for the byte being loaded: stick parity overrides, even
  // parity is the XOR of the data bits, odd parity its complement.
  assign load_xor    = ^load_word;
  assign load_parity = lcr_sp ? ~lcr_eps : (lcr_eps ? load_xor : ~load_xor);

  // End-of-field detection uses the frame format latched at load time.
  assign last_data_idx = {1'b0, wls_reg} + 3'd4;
  assign last_data     = (cnt_reg == last_data_idx);
  assign last_stop     = (cnt_reg == {2'b00, stb_reg});

  // Next-state logic for the framing FSM, shifter, counters and THR.
  always_comb begin
    state_next    = state_reg;
    tsr_next      = tsr_reg;
    cnt_next      = cnt_reg;
    line_next     = line_reg;
    wls_next      = wls_reg;
    stb_next      = stb_reg;
    pen_next      = pen_reg;
    par_next      = par_reg;
    load          = 1'b0;

    if (tick) begin
      case (state_reg)
        IDLE: begin
          if (thr_full_reg) begin
            load = 1'b1;
          end
        end
        START: begin
          line_next  = tsr_reg[0];
          tsr_next   = {1'b0, tsr_reg[7:1]};
          cnt_next   = 3'd0;
          state_next = DATA;
        end
        DATA: begin
          if (last_data) begin
            cnt_next = 3'd0;
            if (pen_reg) begin
              line_next  = par_reg;
              state_next = PARITY;
            end else begin
              line_next  = 1'b1;
              state_next = STOP;
            end
          end else begin
            cnt_next  = cnt_reg + 3'd1;
            line_next = tsr_reg[0];
            tsr_next  = {1'b0, tsr_reg[7:1]};
          end
        end
        PARITY: begin
          line_next  = 1'b1;
          cnt_next   = 3'd0;
          state_next = STOP;
        end
        STOP: begin
          if (last_stop) begin
            if (thr_full_reg) begin
              // Pending byte: go straight into the next start bit.
              load = 1'b1;
            end else begin
              state_next = IDLE;
            end
          end else begin
            cnt_next = cnt_reg + 3'd1;
          end
        end
        default: begin
          line_next  = 1'b1;
          state_next = IDLE;
        end
      endcase
    end

    // TSR load: drive the start bit and capture the frame format.
    if (load) begin
      state_next = START;
      tsr_next   = thr_reg;
      cnt_next   = 3'd0;
      line_next  = 1'b0;
      wls_next   = lcr_wls;
      stb_next   = lcr_stb;
      pen_next   = lcr_pen;
      par_next   = load_parity;
    end
  end

  // THR occupancy: a load empties it, an accepted write fills it. The two
  // never coincide since a write needs an empty THR and a load a full one.
  always_comb begin
    thr_next      = thr_reg;
    thr_full_next = thr_full_reg;
    if (load) begin
      thr_full_next = 1'b0;
    end else if (wr_accept) begin
      thr_next      = thr_data;
      thr_full_next = 1'b1;
    end
  end

  // State registers; reset aborts any frame and discards the THR.
  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      baud_d_reg   <= 1'b1;
      thr_reg      <= 8'h00;
      thr_full_reg <= 1'b0;
      state_reg    <= IDLE;
      tsr_reg      <= 8'h00;
      cnt_reg      <= 3'd0;
      wls_reg      <= 2'b00;
      stb_reg      <= 1'b0;
      pen_reg      <= 1'b0;
      par_reg      <= 1'b0;
      line_reg     <= 1'b1;
    end else begin
      baud_d_reg   <= baud_clock;
      thr_reg      <= thr_next;
      thr_full_reg <= thr_full_next;
      state_reg    <= state_next;
      tsr_reg      <= tsr_next;
      cnt_reg      <= cnt_next;
      wls_reg      <= wls_next;
      stb_reg      <= stb_next;
      pen_reg      <= pen_next;
      par_reg      <= par_next;
      line_reg     <= line_next;
    end
  end

  // Output register: break forces the line low without disturbing sequencing.
  always_ff @(posedge clk_cpu or posedge rst) begin
    if (rst) begin
      tx_out_reg <= 1'b1;
    end else begin
      tx_out_reg <= line_next & ~lcr_bc;
    end
  end

  assign tx_out    = tx_out_reg;
  assign thr_ready = ~thr_full_reg;
  assign tx_busy   = (state_reg != IDLE);
  assign temt      = ~thr_full_reg & (state_reg == IDLE);

endmodule

// File: tb/tb_uart_tx_frame.sv
// Testbench for uart_tx_frame: table of frame formats with hand-derived
// parity and frame length, hand-written timing/back-to-back/break/reset
// sequences, and randomized frames checked against a bit-list model.
module tb_uart_tx_frame;

  localparam int DIV = 16;

  logic       clk_cpu = 1'b0;
  logic       rst;
  logic       baud_clock = 1'b1;
  logic [7:0] thr_data;
  logic       thr_valid;
  logic       thr_ready;
  logic [1:0] lcr_wls;
  logic       lcr_stb, lcr_pen, lcr_eps, lcr_sp, lcr_bc;
  logic       tx_out, tx_busy, temt;

  int n_checks = 0;
  int n_fail   = 0;
  bit baud_en  = 1'b0;
  int baud_cnt = 0;
  bit exp_q[$];

  typedef struct {
    logic [7:0] data;
    logic [1:0] wls;
    logic       stb, pen, eps, sp;
    logic       exp_par;
    int         exp_bits;
  } vec_t;

  vec_t tbl[8];

  uart_tx_frame dut (
    .clk_cpu   (clk_cpu),
    .rst       (rst),
    .baud_clock(baud_clock),
    .thr_data  (thr_data),
    .thr_valid (thr_valid),
    .thr_ready (thr_ready),
    .lcr_wls   (lcr_wls),
    .lcr_stb   (lcr_stb),
    .lcr_pen   (lcr_pen),
    .lcr_eps   (lcr_eps),
    .lcr_sp    (lcr_sp),
    .lcr_bc    (lcr_bc),
    .tx_out    (tx_out),
    .tx_busy   (tx_busy),
    .temt      (temt)
  );

  always #5 clk_cpu = ~clk_cpu;

  // Baud divider stand-in: low for DIV/2 clocks, high for DIV/2, held high
  // while disabled. Updated on the falling clock edge.
  always @(negedge clk_cpu) begin
    if (!baud_en) begin
      baud_cnt   = 0;
      baud_clock = 1'b1;
    end else begin
      baud_clock = (baud_cnt >= DIV / 2);
      baud_cnt   = (baud_cnt + 1) % DIV;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk_cpu);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference parity from the rules: stick forces ~eps, even parity makes the
  // total count of ones even, odd parity makes it odd.
  function automatic bit ref_parity(input logic [7:0] d, input logic [1:0] wls,
                                    input logic eps, input logic sp);
    int ones = 0;
    for (int i = 0; i < int'(wls) + 5; i++) ones += int'(d[i]);
    if (sp) return ~eps;
    if (eps) return (ones % 2) == 1;
    return (ones % 2) == 0;
  endfunction

  // Append the expected line levels of one frame to exp_q.
  task automatic build_frame(input logic [7:0] d, input logic [1:0] wls, input logic stb,
                             input logic pen, input logic par);
    exp_q.push_back(1'b0);
    for (int i = 0; i < int'(wls) + 5; i++) exp_q.push_back(d[i]);
    if (pen) exp_q.push_back(par);
    exp_q.push_back(1'b1);
    if (stb) exp_q.push_back(1'b1);
  endtask

  task automatic set_lcr(input logic [1:0] wls, input logic stb, input logic pen,
                         input logic eps, input logic sp);
    lcr_wls = wls;
    lcr_stb = stb;
    lcr_pen = pen;
    lcr_eps = eps;
    lcr_sp  = sp;
  endtask

  task automatic do_write(input logic [7:0] d);
    thr_data  = d;
    thr_valid = 1'b1;
    step();
    thr_valid = 1'b0;
  endtask

  // Step until the start bit appears; k counts clocks since the call.
  task automatic wait_fall(output int k);
    k = 0;
    while (tx_out !== 1'b0 && k < 2 * DIV + 4) begin
      step();
      k++;
    end
    check("start_bit", tx_out, 1'b0);
    check("busy_at_start", tx_busy, 1'b1);
  endtask

  // Sample tx_out mid-bit for every entry of exp_q (c0 = clocks already
  // elapsed since the start bit), then measure when temt returns.
  task automatic check_seq(input int c0, input int exp_len, input string name);
    int c = c0;
    int nb = exp_q.size();
    logic [31:0] got = '0;
    logic [31:0] want = '0;
    for (int i = 0; i < nb; i++) begin
      int target = i * DIV + DIV / 2;
      if (target < c) continue;
      while (c < target) begin
        step();
        c++;
      end
      got[i]  = tx_out;
      want[i] = exp_q[i];
    end
    while (temt !== 1'b1 && c < exp_len + 4 * DIV) begin
      step();
      c++;
    end
    check({name, "_bits"}, got, want);
    check({name, "_len"}, c, exp_len);
    $display("frame %s: bits=%b len=%0d", name, got[21:0], c);
  endtask

  initial begin
    int k;
    int c;
    int bad;
    logic [7:0] d;
    logic [1:0] w;
    logic s, p, e, sp;

    tbl[0] = '{8'h55, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10};
    tbl[1] = '{8'hC1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 10};
    tbl[2] = '{8'hC1, 2'b10, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 10};
    tbl[3] = '{8'h1F, 2'b00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 9};
    tbl[4] = '{8'hFA, 2'b01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 10};
    tbl[5] = '{8'h80, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 11};
    tbl[6] = '{8'h00, 2'b11, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 11};
    tbl[7] = '{8'hFF, 2'b00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 8};

    rst       = 1'b1;
    thr_data  = 8'h00;
    thr_valid = 1'b0;
    lcr_bc    = 1'b0;
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) step();
    check("rst_tx_out", tx_out, 1'b1);
    check("rst_thr_ready", thr_ready, 1'b1);
    check("rst_tx_busy", tx_busy, 1'b0);
    check("rst_temt", temt, 1'b1);
    rst = 1'b0;
    baud_en = 1'b1;
    repeat (4) step();

    // Table-driven frame formats
    foreach (tbl[i]) begin
      set_lcr(tbl[i].wls, tbl[i].stb, tbl[i].pen, tbl[i].eps, tbl[i].sp);
      do_write(tbl[i].data);
      wait_fall(k);
      check("start_latency", (k >= 1 && k <= DIV + 1), 1'b1);
      exp_q.delete();
      build_frame(tbl[i].data, tbl[i].wls, tbl[i].stb, tbl[i].pen, tbl[i].exp_par);
      check_seq(0, tbl[i].exp_bits * DIV, $sformatf("tbl%0d", i));
    end

    // Exact write-to-start latency against the tick position
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int off = -1; off <= 1; off++) begin
      for (int j = 0; j < 2 * DIV && baud_cnt != DIV / 2 + off; j++) step();
      do_write(8'h5A);
      wait_fall(k);
      check($sformatf("latency_off%0d", off), k, (off == -1) ? 1 : ((off == 0) ? DIV : DIV - 1));
      exp_q.delete();
      build_frame(8'h5A, 2'b11, 1'b0, 1'b0, 1'b0);
      check_seq(0, 10 * DIV, $sformatf("lat%0d", off));
    end

    // Back-to-back with an ignored third write
    do_write(8'hA5);
    wait_fall(k);
    check("b2b_ready_at_start", thr_ready, 1'b1);
    do_write(8'h3C);
    check("b2b_thr_full", thr_ready, 1'b0);
    do_write(8'hFF);
    exp_q.delete();
    build_frame(8'hA5, 2'b11, 1'b0, 1'b0, 1'b0);
    build_frame(8'h3C, 2'b11, 1'b0, 1'b0, 1'b0);
    check_seq(2, 20 * DIV, "b2b");

    // Break asserted in the middle of data bit 4 of 0xF0
    do_write(8'hF0);
    wait_fall(k);
    c = 0;
    while (c < 5 * DIV + 2) begin
      step();
      c++;
    end
    lcr_bc = 1'b1;
    step();
    c++;
    check("break_low", tx_out, 1'b0);
    repeat (3) begin
      step();
      c++;
    end
    check("break_hold", tx_out, 1'b0);
    lcr_bc = 1'b0;
    step();
    c++;
    check("break_release", tx_out, 1'b1);
    exp_q.delete();
    build_frame(8'hF0, 2'b11, 1'b0, 1'b0, 1'b0);
    check_seq(c, 10 * DIV, "break");

    // Randomized frames; LCR is scrambled once the frame has started
    for (int n = 0; n < 24; n++) begin
      d  = 8'($urandom);
      w  = 2'($urandom_range(0, 3));
      s  = 1'($urandom);
      p  = 1'($urandom);
      e  = 1'($urandom);
      sp = 1'($urandom);
      set_lcr(w, s, p, e, sp);
      do_write(d);
      wait_fall(k);
      set_lcr(2'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
      exp_q.delete();
      build_frame(d, w, s, p, ref_parity(d, w, e, sp));
      check_seq(0, (1 + int'(w) + 5 + int'(p) + 1 + int'(s)) * DIV, $sformatf("rnd%0d", n));
    end

    // Reset mid-frame with a byte pending, then a stalled divider
    set_lcr(2'b11, 1'b0, 1'b0, 1'b0, 1'b0);
    do_write(8'h33);
    wait_fall(k);
    do_write(8'h99);
    repeat (3 * DIV) step();
    #2;
    rst = 1'b1;
    baud_en = 1'b0;
    #1;
    check("midrst_tx_out", tx_out, 1'b1);
    check("midrst_thr_ready", thr_ready, 1'b1);
    check("midrst_temt", temt, 1'b1);
    check("midrst_tx_busy", tx_busy, 1'b0);
    repeat (2) step();
    rst = 1'b0;
    step();
    check("after_rst_temt", temt, 1'b1);
    do_write(8'h6B);
    bad = 0;
    repeat (3 * DIV) begin
      step();
      if (tx_out !== 1'b1) bad++;
    end
    check("stall_line_high", bad, 0);
    check("stall_pending", thr_ready, 1'b0);
    check("stall_not_busy", tx_busy, 1'b0);
    $display("stall: byte 6B pending, line held for %0d clocks", 3 * DIV);
    baud_en = 1'b1;
    wait_fall(k);
    exp_q.delete();
    build_frame(8'h6B, 2'b11, 1'b0, 1'b0, 1'b0);
    check_seq(0, 10 * DIV, "after_stall");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
